apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Parametrised APB4 requester that turns a single-command local request port into compliant APB SETUP/ACCESS sequences. It adds byte strobes, a wait-state timeout, error reporting and back-to-back issue without an IDLE bubble. It sits on the master side of the apb2apb bridge, one instance per downstream APB segment.

## Interface
Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH from apb_arch.svh, APB address width
- DATA_WIDTH, default `DATA_WIDTH from apb_arch.svh, data width; must be a multiple of 8
- TIMEOUT, default 16, max ACCESS cycles with ready low before abort; 0 = never abort

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rst_n  in  1  asynchronous reset, active low
- Local request side:
  - start  in  1  request valid
  - cmd_ready  out  1  request accepted when start && cmd_ready
  - wr  in  1  1 = write, 0 = read
  - address  in  ADDR_WIDTH  request address
  - data_in  in  DATA_WIDTH  write data
  - strb  in  DATA_WIDTH/8  write byte enables
  - busy  out  1  transfer in progress
  - done  out  1  one-cycle completion pulse
  - error  out  1  valid with done: slverr or timeout
  - timeout  out  1  valid with done: abort due to TIMEOUT
  - data_out  out  DATA_WIDTH  last successful read data
- APB side:
  - sel, enable, write  out  1  PSEL, PENABLE, PWRITE
  - addr  out  ADDR_WIDTH  PADDR
  - wdata  out  DATA_WIDTH  PWDATA
  - pstrb  out  DATA_WIDTH/8  PSTRB
  - ready, slverr  in  1  PREADY, PSLVERR
  - rdata  in  DATA_WIDTH  PRDATA

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready is combinational: high in IDLE, or in ACCESS when ready=1. It is low in SETUP, in ACCESS with ready=0, and in any abort cycle.
- Accept latches wr, address, data_in and strb into request registers; APB outputs are driven only from these registers.
- Transitions:
  - IDLE to SETUP on accept.
  - SETUP to ACCESS unconditionally.
  - ACCESS with ready=1 goes to SETUP if a new request is accepted in the same cycle (sel stays 1, enable drops); otherwise it goes to IDLE.
  - ACCESS with ready=0 stays in ACCESS until the timeout fires, then goes to IDLE.
- Output values by state:
  - IDLE: sel=0, enable=0.
  - SETUP: sel=1, enable=0.
  - ACCESS: sel=1, enable=1.
  - addr, write, wdata and pstrb are stable from SETUP through the end of ACCESS.
- Reads drive wdata=0 and pstrb=0.
- Timeout:
  - The wait counter clears on entry to ACCESS and increments each ACCESS cycle with ready=0.
  - Abort fires when count == TIMEOUT-1 with ready=0, so the transfer lasts exactly TIMEOUT ACCESS cycles.
  - The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- Completion (ready=1, or abort) is registered and produces in the next cycle:
  - done=1;
  - error = slverr | abort;
  - timeout = abort.
- data_out updates only on a read completing with ready=1 and slverr=0. It holds otherwise, including on error.
- start while cmd_ready=0 is ignored; there is no queue.
- busy = (state != IDLE).

## Timing
- Reset, asynchronous and immediate:
  - state IDLE; all outputs 0, including data_out; request registers 0.
  - Any in-flight transfer is dropped with no done.
- Zero-wait transfer:
  - start in IDLE at cycle 0.
  - SETUP at cycle 1.
  - ACCESS with ready=1 at cycle 2.
  - done and data_out at cycle 3.
- Each wait state adds one cycle.
- Back-to-back: the second SETUP immediately follows the first ACCESS. Sustained rate is one transfer per 2 cycles.
- done, error and timeout are single-cycle pulses. error and timeout are 0 whenever done=0.
- ready and slverr are sampled only in ACCESS. rdata is sampled only when ready=1.

## Structure
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS};
  - the request struct typedef (wr, addr, wdata, strb), parametrised by the header widths.
- Sub-module apb_wait_timer (parameter TIMEOUT):
  - inputs clk, rst_n, clear, tick;
  - output expired;
  - when TIMEOUT=0, expired ties to 0.
- The top holds the FSM, request registers and result registers.

## Test plan
- Write, address 0x10, data 0xDEADBEEF, strb 0xF, ready tied 1:
  - sel rises at cycle 1, enable at cycle 2;
  - done at cycle 3 with error=0.
- Read with ready low for 3 ACCESS cycles, rdata 0x12345678:
  - done at cycle 6;
  - data_out = 0x12345678.
- Read with slverr=1:
  - done with error=1, timeout=0;
  - data_out retains its prior value.
- TIMEOUT=4, ready held 0:
  - exactly 4 ACCESS cycles, then sel=0;
  - done with error=1, timeout=1.
- Three back-to-back writes with start held high:
  - sel stays 1 throughout;
  - enable pattern 0,1,0,1,0,1;
  - three done pulses.
- rst_n asserted during ACCESS:
  - all outputs 0 immediately; no done;
  - a new request after release completes normally.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the APB requester: FSM state encoding and the latched request record.
package apb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // One accepted local command, as held for the duration of an APB transfer.
    typedef struct packed {
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [DEF_STRB_WIDTH-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB4 bus bundle between one requester and one downstream segment.
interface apb_master_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = apb_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = apb_pkg::DEF_DATA_WIDTH
);
    logic                    sel;
    logic                    enable;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    ready;
    logic                    slverr;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output sel, enable, write, addr, wdata, pstrb,
        input  ready, slverr, rdata
    );

    modport slave (
        input  sel, enable, write, addr, wdata, pstrb,
        output ready, slverr, rdata
    );
endinterface

// File: rtl/apb_master_ctrl_wait_timer.sv
// Counts ACCESS wait states and flags the cycle in which the transfer must be aborted.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    if (TIMEOUT == 0) begin : g_never
        assign expired = 1'b0;
    end else begin : g_count
        localparam int unsigned CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] count_q;

        // Wait counter: cleared when entering ACCESS, saturates instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (clear) begin
                count_q <= '0;
            end else if (tick && (count_q < CW'(TIMEOUT))) begin
                count_q <= count_q + 1'b1;
            end
        end

        // Abort in the TIMEOUT-th waiting ACCESS cycle.
        assign expired = tick && (count_q == CW'(TIMEOUT - 1));
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 requester: turns single local commands into SETUP/ACCESS sequences with
// back-to-back issue, wait-state timeout and registered completion status.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    cmd_ready,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    timeout,
    output logic [DATA_WIDTH-1:0]   data_out,
    apb_master_ctrl_if.master       apb
);
    apb_state_e state_q, state_d;

    logic                    req_wr_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [DATA_WIDTH/8-1:0] req_strb_q;

    logic                    done_q, error_q, timeout_q;
    logic [DATA_WIDTH-1:0]   data_out_q;

    logic accept;
    logic expired;
    logic in_access;
    logic complete;

    assign in_access = (state_q == ACCESS);
    assign accept    = start && cmd_ready;
    assign complete  = in_access && (apb.ready || expired);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == SETUP),
        .tick    (in_access && !apb.ready),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and command acceptance; an abort cycle always has ready low.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (start) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.ready) begin
                    cmd_ready = 1'b1;
                    state_d   = start ? SETUP : IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request registers; reads carry zero data and strobes onto the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_strb_q  <= '0;
        end else if (accept) begin
            req_wr_q    <= wr;
            req_addr_q  <= address;
            req_wdata_q <= wr ? data_in : '0;
            req_strb_q  <= wr ? strb : '0;
        end
    end

    // Completion status, presented the cycle after ready or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= complete;
            error_q   <= in_access && ((apb.ready && apb.slverr) || (!apb.ready && expired));
            timeout_q <= in_access && !apb.ready && expired;
        end
    end

    // Read data only captured on a clean read completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (in_access && apb.ready && !apb.slverr && !req_wr_q) begin
            data_out_q <= apb.rdata;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign timeout  = timeout_q;
    assign data_out = data_out_q;

    assign apb.sel    = (state_q != IDLE);
    assign apb.enable = in_access;
    assign apb.write  = req_wr_q;
    assign apb.addr   = req_addr_q;
    assign apb.wdata  = req_wdata_q;
    assign apb.pstrb  = req_strb_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with a configurable APB completer model
// and a completion scoreboard.
module tb_apb_master_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cmd_ready;
    logic          wr = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    strb = '0;
    logic          busy, done, error, timeout;
    logic [DW-1:0] data_out;

    apb_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_ready (cmd_ready),
        .wr        (wr),
        .address   (address),
        .data_in   (data_in),
        .strb      (strb),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .timeout   (timeout),
        .data_out  (data_out),
        .apb       (bus)
    );

    always #5 clk = ~clk;

    // Completer model: ready after wait_cfg waiting ACCESS cycles, or never when hang=1.
    int          wait_cfg = 0;
    logic        hang = 1'b0;
    logic        slverr_cfg = 1'b0;
    logic [DW-1:0] rdata_cfg = '0;
    int          acc_cnt;

    assign bus.ready  = bus.sel && bus.enable && !hang && (acc_cnt == wait_cfg);
    assign bus.slverr = bus.ready && slverr_cfg;
    assign bus.rdata  = bus.ready ? rdata_cfg : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (bus.sel && bus.enable && !bus.ready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    typedef struct {
        logic          err;
        logic          to;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] exp_data = '0;
    int            errors = 0;
    int            checks = 0;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got done=1, required no completion");
            end else begin
                mon_e = sb.pop_front();
                if (error !== mon_e.err || timeout !== mon_e.to || data_out !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_completion: got err=%b to=%b data=%h, required err=%b to=%b data=%h",
                             error, timeout, data_out, mon_e.err, mon_e.to, mon_e.data);
                end
            end
        end
    end

    task automatic push_exp(input logic e, input logic t, input logic [DW-1:0] d);
        exp_t x;
        x.err = e; x.to = t; x.data = d;
        sb.push_back(x);
    endtask

    // Present one command in IDLE for one cycle (caller is #1 after a posedge).
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s);
        wr = w; address = a; data_in = d; strb = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({bus.sel, bus.enable, bus.write, busy, done, error, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {bus.sel, bus.enable, bus.write, busy, done, error, timeout});
        end
        checks++;
        if (bus.addr !== '0 || bus.wdata !== '0 || bus.pstrb !== '0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h pstrb=%h data_out=%h, required all 0",
                     bus.addr, bus.wdata, bus.pstrb, data_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        wait_cfg = 0; hang = 1'b0; slverr_cfg = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_cmd_ready_idle: got %b, required 1", cmd_ready);
        end
        push_exp(1'b0, 1'b0, exp_data);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        // cycle 1: SETUP
        checks++;
        if ({bus.sel, bus.enable, cmd_ready} !== 3'b100) begin
            errors++;
            $display("FAIL wr_setup: got sel/en/rdy=%b, required 100",
                     {bus.sel, bus.enable, cmd_ready});
        end
        checks++;
        if (bus.addr !== 32'h10 || bus.write !== 1'b1 || bus.wdata !== 32'hDEADBEEF
            || bus.pstrb !== 4'hF) begin
            errors++;
            $display("FAIL wr_bus: got addr=%h w=%b wdata=%h pstrb=%h, required 10 1 deadbeef f",
                     bus.addr, bus.write, bus.wdata, bus.pstrb);
        end
        @(posedge clk); #1;
        // cycle 2: ACCESS
        checks++;
        if ({bus.sel, bus.enable, done} !== 3'b110) begin
            errors++;
            $display("FAIL wr_access: got sel/en/done=%b, required 110",
                     {bus.sel, bus.enable, done});
        end
        @(posedge clk); #1;
        // cycle 3: done
        checks++;
        if ({done, error, bus.sel, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_done: got done/err/sel/busy=%b, required 1000",
                     {done, error, bus.sel, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_wait;
        wait_cfg = 3; rdata_cfg = 32'h12345678;
        push_exp(1'b0, 1'b0, 32'h12345678);
        exp_data = 32'h12345678;
        issue(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (bus.wdata !== '0 || bus.pstrb !== '0 || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL rd_bus_zero: got wdata=%h pstrb=%h w=%b, required 0 0 0",
                     bus.wdata, bus.pstrb, bus.write);
        end
        for (int c = 1; c < 6; c++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rd_early_done: cycle %0d got done=%b, required 0", c, done);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || data_out !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_done_c6: got done=%b data=%h, required 1 12345678", done, data_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slverr;
        wait_cfg = 0; slverr_cfg = 1'b1; rdata_cfg = 32'hCAFEF00D;
        push_exp(1'b1, 1'b0, exp_data);
        issue(1'b0, 32'h30, '0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({done, error, timeout} !== 3'b110 || data_out !== 32'h12345678) begin
            errors++;
            $display("FAIL slverr: got d/e/t=%b data=%h, required 110 12345678",
                     {done, error, timeout}, data_out);
        end
        slverr_cfg = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int n_acc;
        logic dropped;
        n_acc = 0; dropped = 1'b0;
        hang = 1'b1;
        push_exp(1'b1, 1'b1, exp_data);
        issue(1'b0, 32'h40, '0, 4'h0);
        for (int c = 0; c < 20 && !dropped; c++) begin
            @(posedge clk); #1;
            if (bus.enable) n_acc++;
            if (!bus.sel) dropped = 1'b1;
        end
        checks++;
        if (!dropped || n_acc != 4) begin
            errors++;
            $display("FAIL timeout_len: got dropped=%b access_cycles=%0d, required 1 4",
                     dropped, n_acc);
        end
        checks++;
        if ({done, error, timeout} !== 3'b111) begin
            errors++;
            $display("FAIL timeout_flags: got d/e/t=%b, required 111", {done, error, timeout});
        end
        hang = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] dtab [3];
        logic [5:0] en_pat;
        logic [5:0] sel_pat;
        int k, n_done, n_setup;
        logic acc;
        dtab[0] = 32'h11111111; dtab[1] = 32'h22222222; dtab[2] = 32'h33333333;
        k = 0; n_done = 0; n_setup = 0; en_pat = '0; sel_pat = '0;
        wait_cfg = 0;
        wr = 1'b1; address = 32'h100; data_in = dtab[0]; strb = 4'h3; start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            acc = start && cmd_ready;
            if (acc) push_exp(1'b0, 1'b0, exp_data);
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k == 3) start = 1'b0;
                else begin
                    data_in = dtab[k]; address = 32'h100 + 32'(4 * k);
                end
            end
            if (c < 6) begin
                en_pat[5-c]  = bus.enable;
                sel_pat[5-c] = bus.sel;
            end
            if (bus.sel && !bus.enable) begin
                checks++;
                if (n_setup > 2 || bus.wdata !== dtab[n_setup]) begin
                    errors++;
                    $display("FAIL b2b_wdata: setup %0d got %h, required %h",
                             n_setup, bus.wdata, dtab[n_setup % 3]);
                end
                n_setup++;
            end
            if (done) n_done++;
        end
        checks++;
        if (en_pat !== 6'b010101 || sel_pat !== 6'b111111) begin
            errors++;
            $display("FAIL b2b_pattern: got en=%b sel=%b, required 010101 111111", en_pat, sel_pat);
        end
        checks++;
        if (n_done != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d, required 3", n_done);
        end
    endtask

    task automatic test_reset_mid;
        hang = 1'b1;
        issue(1'b0, 32'h50, '0, 4'h0);
        @(posedge clk); #1;
        checks++;
        if (bus.enable !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_access: got enable=%b, required 1", bus.enable);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sel, bus.enable, busy, done, error, timeout} !== 6'b0 || data_out !== '0
            || bus.addr !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b data=%h addr=%h, required 0 0 0",
                     {bus.sel, bus.enable, busy, done, error, timeout}, data_out, bus.addr);
        end
        exp_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; hang = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_done: got done=%b, required 0", done);
            end
        end
        push_exp(1'b0, 1'b0, 32'hA5A5A5A5);
        exp_data = 32'hA5A5A5A5;
        wait_cfg = 1; rdata_cfg = 32'hA5A5A5A5;
        issue(1'b0, 32'h60, '0, 4'h0);
        begin : wait_done
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(posedge clk); #1;
                if (done) seen = 1'b1;
            end
            checks++;
            if (!seen || data_out !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL rstmid_after: got seen=%b data=%h, required 1 a5a5a5a5",
                         seen, data_out);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        @(posedge clk); #1;
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
